sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Shares the single-port 512x8 instruction/data SRAM between three requesters: the serial loader/debug controller (IO), CPU instruction fetch (IF) and CPU data access (DM).
- Arbitrates every cycle, registers the winning access onto the SRAM pins, and returns read data with a requester tag.
- Sits between the SRAM macro (active-low CEN/WEN, 1-cycle read latency) and the loader/CPU, replacing ad-hoc address/enable muxing at top level.

Parameters:
- ADDR_WIDTH, 9, SRAM address width.
- DATA_WIDTH, 8, SRAM data width.
- STAT_WIDTH, 16, width of grant statistics counters (optional feature only).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- IO_REQ / IF_REQ / DM_REQ  in  1 each  access request; held until granted.
- IO_WE / DM_WE  in  1 each  1 = write, 0 = read. IF is read-only.
- IO_ADDR / IF_ADDR / DM_ADDR  in  ADDR_WIDTH each  access address.
- IO_WDATA / DM_WDATA  in  DATA_WIDTH each  write data.
- IO_LOCK  in  1  loader owns memory; IF/DM are never granted while high.
- IO_GNT / IF_GNT / DM_GNT  out  1 each  combinational grant; transfer occurs on the edge where REQ & GNT.
- RVLD  out  1  read data valid.
- RID  out  2  requester of RDATA (shared encoding).
- RDATA  out  DATA_WIDTH  read data (mirrors SRAM_Q while RVLD).
- SRAM_CEN_N  out  1  macro chip enable, active low.
- SRAM_WEN_N  out  1  macro write enable, active low.
- SRAM_A  out  ADDR_WIDTH  macro address.
- SRAM_D  out  DATA_WIDTH  macro write data.
- SRAM_Q  in  DATA_WIDTH  macro read data.
- STAT_IO / STAT_IF / STAT_DM  out  STAT_WIDTH each  grant counters (optional feature).

Behaviour:
- Reset values (applied on the first edge with RST=1):
  - SRAM_CEN_N=1, SRAM_WEN_N=1, SRAM_A=0, SRAM_D=0.
  - RVLD=0, RID=0, RDATA=0.
  - RR pointer = IF; STAT_* = 0.
  - GNT outputs are 0 while RST=1.
- Priority:
  - IO is highest priority and fixed.
  - IF vs DM is round-robin. The pointer names the preferred port and flips to the other port after each CPU grant.
  - IO_LOCK=1 masks IF/DM completely, whether or not IO_REQ is asserted.
- At most one GNT per cycle; GNT is asserted only when the matching REQ is asserted.
- Pipeline, one access per cycle, no bubbles:
  - Cycle N: REQ & GNT at the edge.
  - Cycle N+1: SRAM_CEN_N=0, SRAM_A/SRAM_D/SRAM_WEN_N registered from the winner.
  - Cycle N+2: for reads, RVLD=1, RID=winner, RDATA=SRAM_Q. Read latency is 2 cycles from accept.
- Writes produce no RVLD; the grant is the only acknowledgement.
- Idle cycle (no grant): SRAM_CEN_N=1 and SRAM_WEN_N=1 next cycle. A/D hold their previous values.
- Back-to-back write X then read X completes in order; the read returns the new data.
- Boundaries:
  - ADDR above 511 is impossible by width; there is no wrap logic.
  - A requester dropping REQ without a grant is legal (the request is withdrawn).
- RST asserted mid-operation: in-flight accesses are discarded. SRAM_CEN_N=1 and RVLD=0 on the next cycle, and no stale RVLD follows reset release.
- Simultaneous IO/IF/DM requests: IO wins; the RR pointer does not change on an IO grant.

Optional Feature:
- Macro SRAM_ARB_STATS_EN.
  - Defined: STAT_IO/IF/DM count accepted transfers per requester, saturate at all-ones, and are cleared by RST.
  - Undefined: the STAT_* ports still exist, are tied to 0, and no counter flops are inferred.

Decomposition:
- Shared definitions file/package holds:
  - requester ID encoding: ID_IO=2'd0, ID_IF=2'd1, ID_DM=2'd2;
  - SRAM ADDR/DATA width defaults.
- One sub-module, sram_rr_pick: a 2-input round-robin picker holding the pointer, with inputs req[1:0] and advance, and output one-hot gnt.

Test Plan:
1. Reset, then IO write: IO_WE=1, IO_ADDR=0x020, IO_WDATA=0xA5. Then IO read of 0x020 → RVLD two cycles after accept, RID=0, RDATA=0xA5. SRAM_CEN_N low for exactly one cycle per access.
2. IF_REQ and DM_REQ (read) held continuously for 6 cycles → grants alternate IF, DM, IF, DM, IF, DM. RVLD for 6 consecutive cycles with RID alternating 1, 2.
3. All three REQ high with IO_LOCK=0 → IO_GNT only. Then IO_REQ drops → IF granted first, confirming the pointer was unchanged by the IO grant.
4. IO_LOCK=1 with IF_REQ=1 and DM_REQ=1, IO idle → no GNT, SRAM_CEN_N=1. Drop IO_LOCK → CPU grants resume the next cycle.
5. DM write 0x3C to 0x004, then IF read of 0x004 on the next cycle → RDATA=0x3C, RID=1.
6. IF read accepted, RST pulsed in the following cycle → RVLD=0 throughout and after release; STAT_IF=0 with SRAM_ARB_STATS_EN defined, and STAT_IF=1 after one later IF accept.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg: shared requester IDs and SRAM geometry
// for the 512x8 instruction/data SRAM arbiter.
package sram_port_arbiter_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    ID_IO = 2'd0,
    ID_IF = 2'd1,
    ID_DM = 2'd2
  } req_id_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: requester handshakes, read return,
// SRAM macro pins and grant statistics.
interface sram_port_arbiter_if
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int STAT_WIDTH = STAT_W
);

  logic                  IO_REQ;
  logic                  IF_REQ;
  logic                  DM_REQ;
  logic                  IO_WE;
  logic                  DM_WE;
  logic [ADDR_WIDTH-1:0] IO_ADDR;
  logic [ADDR_WIDTH-1:0] IF_ADDR;
  logic [ADDR_WIDTH-1:0] DM_ADDR;
  logic [DATA_WIDTH-1:0] IO_WDATA;
  logic [DATA_WIDTH-1:0] DM_WDATA;
  logic                  IO_LOCK;
  logic                  IO_GNT;
  logic                  IF_GNT;
  logic                  DM_GNT;
  logic                  RVLD;
  logic [1:0]            RID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic                  SRAM_CEN_N;
  logic                  SRAM_WEN_N;
  logic [ADDR_WIDTH-1:0] SRAM_A;
  logic [DATA_WIDTH-1:0] SRAM_D;
  logic [DATA_WIDTH-1:0] SRAM_Q;
  logic [STAT_WIDTH-1:0] STAT_IO;
  logic [STAT_WIDTH-1:0] STAT_IF;
  logic [STAT_WIDTH-1:0] STAT_DM;

  modport slave (
    input  IO_REQ, IF_REQ, DM_REQ,
    input  IO_WE, DM_WE,
    input  IO_ADDR, IF_ADDR, DM_ADDR,
    input  IO_WDATA, DM_WDATA,
    input  IO_LOCK,
    output IO_GNT, IF_GNT, DM_GNT,
    output RVLD, RID, RDATA,
    output SRAM_CEN_N, SRAM_WEN_N,
    output SRAM_A, SRAM_D,
    input  SRAM_Q,
    output STAT_IO, STAT_IF, STAT_DM
  );

  modport master (
    output IO_REQ, IF_REQ, DM_REQ,
    output IO_WE, DM_WE,
    output IO_ADDR, IF_ADDR, DM_ADDR,
    output IO_WDATA, DM_WDATA,
    output IO_LOCK,
    input  IO_GNT, IF_GNT, DM_GNT,
    input  RVLD, RID, RDATA,
    input  SRAM_CEN_N, SRAM_WEN_N,
    input  SRAM_A, SRAM_D,
    output SRAM_Q,
    input  STAT_IO, STAT_IF, STAT_DM
  );

endinterface

// File: rtl/sram_rr_pick.sv
// sram_rr_pick: 2-input round-robin picker, req[0]=IF, req[1]=DM.
// The pointer moves to the loser after every advance.
module sram_rr_pick
  import sram_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (ptr == 1'b0)
      gnt = req[0] ? 2'b01 : {req[1], 1'b0};
    else
      gnt = req[1] ? 2'b10 : {1'b0, req[0]};
  end

  // ptr=1 prefers DM: set it whenever IF just won
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= 1'b0;
    else if (advance)
      ptr <= gnt[0];
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: IO/IF/DM access to one SRAM macro.
// SRAM_ARB_STATS_EN enables per-requester grant counters.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int STAT_WIDTH = STAT_W
)(
  input logic                CLK,
  input logic                RST,
  sram_port_arbiter_if.slave bus
);

  logic                  io_gnt;
  logic                  cpu_ok;
  logic [1:0]            cpu_req;
  logic [1:0]            cpu_gnt;

  logic                  win_vld;
  logic                  win_we;
  logic                  win_ld_d;
  req_id_e               win_id;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  logic                  cen_n;
  logic                  wen_n;
  logic [ADDR_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] d;
  logic                  rd_pend;
  req_id_e               rd_id;
  logic                  rvld;
  req_id_e               rid;

  // IO always wins; lock keeps the CPU out even when IO idles
  assign io_gnt  = bus.IO_REQ & ~RST;
  assign cpu_ok  = ~RST & ~bus.IO_REQ & ~bus.IO_LOCK;
  assign cpu_req = {bus.DM_REQ, bus.IF_REQ} & {2{cpu_ok}};

  sram_rr_pick u_pick (
    .clk     (CLK),
    .rst     (RST),
    .req     (cpu_req),
    .advance (|cpu_gnt),
    .gnt     (cpu_gnt)
  );

  assign bus.IO_GNT = io_gnt;
  assign bus.IF_GNT = cpu_gnt[0];
  assign bus.DM_GNT = cpu_gnt[1];

  always_comb begin
    win_vld   = 1'b0;
    win_we    = 1'b0;
    win_ld_d  = 1'b0;
    win_id    = ID_IO;
    win_addr  = bus.IO_ADDR;
    win_wdata = bus.IO_WDATA;
    unique case (1'b1)
      io_gnt: begin
        win_vld  = 1'b1;
        win_we   = bus.IO_WE;
        win_ld_d = 1'b1;
      end
      cpu_gnt[0]: begin
        win_vld  = 1'b1;
        win_id   = ID_IF;
        win_addr = bus.IF_ADDR;
      end
      cpu_gnt[1]: begin
        win_vld   = 1'b1;
        win_we    = bus.DM_WE;
        win_ld_d  = 1'b1;
        win_id    = ID_DM;
        win_addr  = bus.DM_ADDR;
        win_wdata = bus.DM_WDATA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cen_n   <= 1'b1;
      wen_n   <= 1'b1;
      a       <= '0;
      d       <= '0;
      rd_pend <= 1'b0;
      rd_id   <= ID_IO;
      rvld    <= 1'b0;
      rid     <= ID_IO;
    end else begin
      cen_n   <= ~win_vld;
      wen_n   <= ~(win_vld & win_we);
      if (win_vld)
        a <= win_addr;
      if (win_ld_d)
        d <= win_wdata;
      rd_pend <= win_vld & ~win_we;
      rd_id   <= win_id;
      rvld    <= rd_pend;
      if (rd_pend)
        rid <= rd_id;
    end
  end

  assign bus.SRAM_CEN_N = cen_n;
  assign bus.SRAM_WEN_N = wen_n;
  assign bus.SRAM_A     = a;
  assign bus.SRAM_D     = d;
  assign bus.RVLD       = rvld;
  assign bus.RID        = rid;
  assign bus.RDATA      = rvld ? bus.SRAM_Q : '0;

`ifdef SRAM_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] stat_io;
  logic [STAT_WIDTH-1:0] stat_if;
  logic [STAT_WIDTH-1:0] stat_dm;

  // saturating: counters stick at all-ones
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_io <= '0;
      stat_if <= '0;
      stat_dm <= '0;
    end else begin
      if (io_gnt && !(&stat_io))
        stat_io <= stat_io + 1'b1;
      if (cpu_gnt[0] && !(&stat_if))
        stat_if <= stat_if + 1'b1;
      if (cpu_gnt[1] && !(&stat_dm))
        stat_dm <= stat_dm + 1'b1;
    end
  end

  assign bus.STAT_IO = stat_io;
  assign bus.STAT_IF = stat_if;
  assign bus.STAT_DM = stat_dm;
`else
  assign bus.STAT_IO = {STAT_WIDTH{1'b0}};
  assign bus.STAT_IF = {STAT_WIDTH{1'b0}};
  assign bus.STAT_DM = {STAT_WIDTH{1'b0}};
`endif

endmodule
